// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: walks a combinational ROM from pc, hands words to
// decode over valid/ready, and stops on HALT_WORD. Optional macro: FETCH_COUNT_EN.
module fetch_sequencer #(
  parameter int          ADDR_W    = 6,
  parameter logic [15:0] HALT_WORD = 16'hE000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_data,
  output logic [15:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              busy,
  output logic              halted,
  output logic [15:0]       fetch_count,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic              load;

  // Handshake: a beat transfers on any edge where instr_valid && instr_ready;
  // once raised, instr/instr_pc hold until that transfer or a flush.
  assign load      = (state == RUN) && !redirect_valid && (!instr_valid || instr_ready);
  assign imem_addr = pc;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      busy        <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pc    <= '0;
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (redirect_valid) begin
            pc          <= redirect_pc;
            instr_valid <= 1'b0;
          end else if (load) begin
            if (imem_data == HALT_WORD) begin
              // pc stays on the halt word so imem_addr shows where we stopped
              instr_valid <= 1'b0;
              state       <= HALT;
              busy        <= 1'b0;
              halted      <= 1'b1;
            end else begin
              instr       <= imem_data;
              instr_pc    <= pc;
              instr_valid <= 1'b1;
              pc          <= pc + 1'b1;
            end
          end
        end
        HALT: begin
          if (start || redirect_valid) begin
            pc     <= start ? '0 : redirect_pc;
            state  <= RUN;
            busy   <= 1'b1;
            halted <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef FETCH_COUNT_EN
  logic [15:0] count_q;
  logic        accept;

  assign accept      = instr_valid && instr_ready && (state == RUN);
  assign fetch_count = count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (accept && (count_q != 16'hFFFF)) begin
      count_q <= count_q + 16'd1;
    end
  end
`else
  assign fetch_count = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus a randomized run, all
// outputs compared each cycle against a transaction-level reference model.
module tb_fetch_sequencer;
  localparam int          ADDR_W = 6;
  localparam int          DEPTH  = 1 << ADDR_W;
  localparam logic [15:0] HALT_W = 16'hE000;

  logic              clk = 1'b0;
  logic              reset, start, instr_ready, redirect_valid;
  logic [ADDR_W-1:0] redirect_pc, imem_addr, instr_pc;
  logic [15:0]       imem_data, instr, fetch_count;
  logic              instr_valid, busy, halted;
  logic [1:0]        state_dbg;

  logic [15:0] rom [DEPTH];

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  typedef enum int {M_IDLE, M_RUN, M_HALT} mode_t;
  mode_t       m_mode;
  int          m_pc;
  bit          m_valid;
  logic [15:0] m_instr;
  int          m_ipc;
  int          m_count;

  fetch_sequencer #(.ADDR_W(ADDR_W), .HALT_WORD(HALT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .imem_addr(imem_addr),
    .imem_data(imem_data), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .busy(busy), .halted(halted), .fetch_count(fetch_count),
    .state_dbg(state_dbg)
  );

  assign imem_data = rom[imem_addr];

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    do w = 16'($urandom); while (w == HALT_W);
    return w;
  endfunction

  // Advance the model by one clock edge with the inputs that were applied.
  task automatic model_edge(input bit rst, input bit st, input bit rv, input int rpc, input bit rdy);
    if (rst) begin
      m_mode = M_IDLE; m_pc = 0; m_valid = 0; m_instr = '0; m_ipc = 0; m_count = 0;
      return;
    end
    case (m_mode)
      M_IDLE: if (st) begin m_pc = 0; m_mode = M_RUN; end
      M_RUN: begin
        if (m_valid && rdy && m_count < 65535) m_count++;
        if (rv) begin
          m_pc = rpc; m_valid = 0;
        end else if (!m_valid || rdy) begin
          if (rom[m_pc] == HALT_W) begin
            m_mode = M_HALT; m_valid = 0;
          end else begin
            m_instr = rom[m_pc]; m_ipc = m_pc; m_valid = 1; m_pc = (m_pc + 1) % DEPTH;
          end
        end
      end
      M_HALT: begin
        if (st) begin m_pc = 0; m_mode = M_RUN; end
        else if (rv) begin m_pc = rpc; m_mode = M_RUN; end
      end
      default: ;
    endcase
  endtask

  task automatic compare_model();
    int exp_count;
`ifdef FETCH_COUNT_EN
    exp_count = m_count;
`else
    exp_count = 0;
`endif
    check("m_valid", 32'(instr_valid), 32'(m_valid));
    check("m_addr", 32'(imem_addr), 32'(m_pc));
    check("m_busy", 32'(busy), 32'(m_mode == M_RUN));
    check("m_halted", 32'(halted), 32'(m_mode == M_HALT));
    check("m_count", 32'(fetch_count), 32'(exp_count));
    if (m_valid) begin
      check("m_instr", 32'(instr), 32'(m_instr));
      check("m_ipc", 32'(instr_pc), 32'(m_ipc));
    end
  endtask

  task automatic step(input bit rst, input bit st, input bit rv, input int rpc, input bit rdy);
    reset = rst; start = st; redirect_valid = rv;
    redirect_pc = ADDR_W'(rpc); instr_ready = rdy;
    @(posedge clk);
    #1;
    model_edge(rst, st, rv, rpc, rdy);
    compare_model();
  endtask

  initial begin
    int exp10;
    reset = 1'b1; start = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) rom[i] = rand_word();
    rom[0] = 16'h1F8C; rom[1] = 16'h407A; rom[2] = 16'h1B26; rom[3] = HALT_W;

    // reset state
    step(1, 1, 1, 9, 1);
    step(1, 0, 0, 0, 1);
    check("rst_valid", 32'(instr_valid), 0);
    check("rst_addr", 32'(imem_addr), 0);
    check("rst_instr", 32'(instr), 0);
    check("rst_ipc", 32'(instr_pc), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_count", 32'(fetch_count), 0);

    // redirect ignored in IDLE
    step(0, 0, 1, 12, 1);
    check("idle_redirect_busy", 32'(busy), 0);
    check("idle_redirect_addr", 32'(imem_addr), 0);

    // straight-line run into halt
    step(0, 1, 0, 0, 1);
    check("start_busy", 32'(busy), 1);
    check("start_valid", 32'(instr_valid), 0);
    step(0, 0, 0, 0, 1);
    check("beat0_pc", 32'(instr_pc), 0);
    check("beat0_instr", 32'(instr), 32'h1F8C);
    step(0, 0, 0, 0, 1);
    check("beat1_pc", 32'(instr_pc), 1);
    check("beat1_instr", 32'(instr), 32'h407A);
    step(0, 0, 0, 0, 1);
    check("beat2_pc", 32'(instr_pc), 2);
    check("beat2_instr", 32'(instr), 32'h1B26);
    step(0, 0, 0, 0, 1);
    check("halt_halted", 32'(halted), 1);
    check("halt_valid", 32'(instr_valid), 0);
    check("halt_addr", 32'(imem_addr), 3);

    // stall: beat held for three cycles, nothing lost
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0);
      check("stall_valid", 32'(instr_valid), 1);
      check("stall_instr", 32'(instr), 32'h1F8C);
      check("stall_pc", 32'(instr_pc), 0);
    end
    step(0, 0, 0, 0, 1);
    check("after_stall_pc", 32'(instr_pc), 1);

    // redirect flush while valid at pc 5
    rom[3] = 16'h3333;
    step(1, 0, 0, 0, 1);
    step(0, 1, 0, 0, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1);
    check("pre_redirect_pc", 32'(instr_pc), 5);
    step(0, 0, 1, 20, 1);
    check("flush_valid", 32'(instr_valid), 0);
    check("flush_addr", 32'(imem_addr), 20);
    step(0, 0, 0, 0, 1);
    check("target_pc", 32'(instr_pc), 20);
    check("target_instr", 32'(instr), 32'(rom[20]));

    // wrap from top of memory
    step(0, 0, 1, 62, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    check("wrap_top_pc", 32'(instr_pc), 63);
    step(0, 0, 0, 0, 1);
    check("wrap_zero_pc", 32'(instr_pc), 0);

    // restart from HALT by redirect, then by start+redirect
    rom[40] = HALT_W;
    step(0, 0, 1, 40, 1);
    step(0, 0, 0, 0, 1);
    check("halt40_halted", 32'(halted), 1);
    check("halt40_addr", 32'(imem_addr), 40);
    step(0, 0, 1, 7, 1);
    check("hredir_busy", 32'(busy), 1);
    check("hredir_halted", 32'(halted), 0);
    step(0, 0, 0, 0, 1);
    check("hredir_pc", 32'(instr_pc), 7);
    step(0, 0, 1, 40, 1);
    step(0, 0, 0, 0, 1);
    step(0, 1, 1, 9, 1);
    check("hboth_addr", 32'(imem_addr), 0);
    check("hboth_busy", 32'(busy), 1);
    step(0, 0, 0, 0, 1);
    check("hboth_pc", 32'(instr_pc), 0);

    // ten accepts then reset
`ifdef FETCH_COUNT_EN
    exp10 = 10;
`else
    exp10 = 0;
`endif
    step(1, 0, 0, 0, 1);
    step(0, 1, 0, 0, 1);
    for (int i = 0; i < 11; i++) step(0, 0, 0, 0, 1);
    check("count_ten", 32'(fetch_count), 32'(exp10));
    step(1, 0, 0, 0, 1);
    check("count_reset", 32'(fetch_count), 0);

    // randomized run against the model
    for (int i = 0; i < DEPTH; i++)
      rom[i] = ($urandom_range(0, 99) < 6) ? HALT_W : rand_word();
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 99) < 6,
           $urandom_range(0, 99) < 8,
           int'($urandom_range(0, DEPTH - 1)),
           $urandom_range(0, 99) < 70);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter ADDR_W, default 6, is the instruction address width; the memory depth is 2^ADDR_W words.
REQ-002 Parameter HALT_WORD, default 16'hE000, is the 16-bit instruction word that terminates fetching.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  begin execution at address 0 (honoured in IDLE and HALT).
REQ-006 imem_addr  output  ADDR_W  instruction memory read address, driven directly from the pc register.
REQ-007 imem_data  input  16  instruction word at imem_addr, valid in the same cycle (combinational ROM).
REQ-008 instr  output  16  fetched instruction toward decode.
REQ-009 instr_pc  output  ADDR_W  address from which instr was fetched.
REQ-010 instr_valid  output  1  instr/instr_pc hold a fetched instruction.
REQ-011 instr_ready  input  1  decode accepts instr this cycle.
REQ-012 redirect_valid  input  1  branch/jump redirect request.
REQ-013 redirect_pc  input  ADDR_W  redirect target address.
REQ-014 busy  output  1  high while in RUN.
REQ-015 halted  output  1  high while in HALT.
REQ-016 fetch_count  output  16  number of instructions accepted by decode (see Configuration).

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, RUN and HALT.
REQ-018 IDLE: on start, the FSM SHALL set pc=0 and move to RUN; redirect_valid SHALL be ignored in IDLE.
REQ-019 Load condition: state==RUN, redirect_valid==0, and (instr_valid==0 or instr_ready==1).
REQ-020 On a load when imem_data!=HALT_WORD, the block SHALL register instr=imem_data, instr_pc=pc, instr_valid=1, and pc=pc+1 modulo 2^ADDR_W (address 2^ADDR_W-1 wraps to 0).
REQ-021 On a load when imem_data==HALT_WORD, the block SHALL clear instr_valid, leave pc at the halt address, and enter HALT; the halt word SHALL never be presented to decode.
REQ-022 Accept condition: instr_valid and instr_ready are both high; with no load in that cycle, instr_valid SHALL clear at the next edge.
REQ-023 While instr_valid==1 and instr_ready==0, instr and instr_pc SHALL remain stable.
REQ-024 In RUN, redirect_valid SHALL take priority: pc=redirect_pc, instr_valid=0 at the next edge (flush), and no load occurs that cycle.
REQ-025 A redirect coincident with an accept SHALL count as an accept and still flush.
REQ-026 Latency: after start is sampled at edge E, the instruction at address 0 SHALL be valid after edge E+1; after a redirect at edge E, the target instruction SHALL be valid after edge E+1.
REQ-027 Throughput: with instr_ready held high, one instruction SHALL be delivered per cycle.
REQ-028 HALT: start SHALL restart at pc=0 (to RUN); redirect_valid SHALL set pc=redirect_pc and go to RUN; start and redirect asserted together SHALL favour start.
REQ-029 busy SHALL be high only in RUN, and halted SHALL be high only in HALT.

Reset
REQ-030 Reset SHALL take priority over all inputs and produce: state=IDLE, pc=0, instr=0, instr_pc=0, instr_valid=0, busy=0, halted=0, fetch_count=0.
REQ-031 A reset asserted mid-run SHALL discard any pending instruction with no accept counted.

Configuration
REQ-032 With macro FETCH_COUNT_EN defined, fetch_count SHALL increment by 1 on every accept, saturating at 16'hFFFF and clearing only on reset.
REQ-033 Without FETCH_COUNT_EN, fetch_count SHALL be constant 0 and no counter register SHALL be synthesised.

Verification
REQ-034 Reset, start, ready=1, ROM words 0..3 = 16'h1F8C,16'h407A,16'h1B26,HALT_WORD -> three valid beats with pc 0,1,2 on consecutive cycles, then halted=1 and imem_addr=3.
REQ-035 Same ROM, ready low for 3 cycles after the first valid -> instr=16'h1F8C and instr_pc=0 held stable for all 3 cycles, no beat lost.
REQ-036 redirect_valid=1 with redirect_pc=20 while valid at pc=5 -> instr_valid=0 the next cycle, then a beat with instr_pc=20 and no beat for pc 6.
REQ-037 pc=63 non-halt with ADDR_W=6 -> beat with instr_pc=63, then the next beat at instr_pc=0.
REQ-038 In HALT, redirect to 7 -> busy=1 and a beat at pc=7; in HALT, start+redirect together -> restart at pc 0.
REQ-039 With FETCH_COUNT_EN, 10 accepts then a reset -> fetch_count reads 10 before the reset and 0 after; without the macro, fetch_count stays 0.
